// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS multicycle core: multiply/divide sequencer
// state encoding, default operand width and the exception cause it raises.
package mips_pkg;

  localparam int MDU_WIDTH = 32;

  // Cause code the control unit records when a DIV completes with b == 0.
  localparam logic [4:0] MDU_CAUSE = 5'h0c;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MULT = 3'd1,
    DIV  = 3'd2,
    DFIX = 3'd3,
    DONE = 3'd4
  } mdu_state_t;

endpackage

// File: rtl/mult_div_seq_div_restore_step.sv
// One restoring-division step on unsigned magnitudes: shift {rem, quo} left,
// trial-subtract the divisor and keep or restore the partial remainder.
module div_restore_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] rem_shift;
  logic           fits;

  assign rem_shift = {rem, quo[WIDTH-1]};
  assign fits      = (rem_shift >= {1'b0, divisor});

  // The kept difference is below the divisor, so WIDTH bits always hold it.
  assign rem_next  = fits ? (rem_shift[WIDTH-1:0] - divisor) : rem_shift[WIDTH-1:0];
  assign quo_next  = {quo[WIDTH-2:0], fits};

endmodule

// File: rtl/mult_div_seq.sv
// Multicycle signed MULT/DIV sequencer owning the HI/LO pair: radix-2 Booth
// multiply, restoring divide on magnitudes with a sign-fix cycle.
module mult_div_seq
  import mips_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  mdu_state_t state, next_state;

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] mcand;
  logic [2*WIDTH:0] acc;
  logic             q_m1;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic             sign_a;
  logic             sign_b;

  logic             last_step;
  logic             div_by_zero_req;
  logic [WIDTH:0]   mcand_ext;
  logic [WIDTH:0]   booth_upper;
  logic [2*WIDTH:0] booth_next;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  assign last_step       = (count == CW'(1));
  assign div_by_zero_req = start_div && !start_mult && (b == '0);

  // The upper half carries one guard bit so subtracting the most negative
  // multiplicand cannot overflow the partial product.
  assign mcand_ext = {mcand[WIDTH-1], mcand};

  always_comb begin
    booth_upper = acc[2*WIDTH:WIDTH];
    case ({acc[0], q_m1})
      2'b01:   booth_upper = acc[2*WIDTH:WIDTH] + mcand_ext;
      2'b10:   booth_upper = acc[2*WIDTH:WIDTH] - mcand_ext;
      default: booth_upper = acc[2*WIDTH:WIDTH];
    endcase
    booth_next = {booth_upper[WIDTH], booth_upper, acc[WIDTH-1:1]};
  end

  div_restore_step #(
    .WIDTH(WIDTH)
  ) u_div_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (divisor),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start_mult)          next_state = MULT;
        else if (div_by_zero_req) next_state = DONE;
        else if (start_div)      next_state = DIV;
      end
      MULT:    if (last_step) next_state = DONE;
      DIV:     if (last_step) next_state = DFIX;
      DFIX:    next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      count    <= '0;
      mcand    <= '0;
      acc      <= '0;
      q_m1     <= 1'b0;
      divisor  <= '0;
      rem      <= '0;
      quo      <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
    end else begin
      busy     <= (next_state != IDLE);
      done     <= (next_state == DONE);
      div_zero <= (state == IDLE) && div_by_zero_req;
      case (state)
        IDLE: begin
          if (start_mult) begin
            mcand <= a;
            acc   <= {{(WIDTH+1){1'b0}}, b};
            q_m1  <= 1'b0;
            count <= CW'(WIDTH);
          end else if (start_div && (b != '0)) begin
            divisor <= b[WIDTH-1] ? -b : b;
            quo     <= a[WIDTH-1] ? -a : a;
            rem     <= '0;
            sign_a  <= a[WIDTH-1];
            sign_b  <= b[WIDTH-1];
            count   <= CW'(WIDTH);
          end
        end
        MULT: begin
          acc   <= booth_next;
          q_m1  <= acc[0];
          count <= count - CW'(1);
          if (last_step) begin
            hi <= booth_next[2*WIDTH-1:WIDTH];
            lo <= booth_next[WIDTH-1:0];
          end
        end
        DIV: begin
          rem   <= rem_next;
          quo   <= quo_next;
          count <= count - CW'(1);
        end
        DFIX: begin
          lo <= (sign_a ^ sign_b) ? -quo : quo;
          hi <= sign_a ? -rem : rem;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_seq.sv
// Directed self-checking bench for mult_div_seq: latency, results, divide by
// zero, start priority, ignored starts and mid-operation reset.
module tb_mult_div_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_mult;
  logic        start_div;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  int lat;
  int pulses;

  mult_div_seq dut (
    .clk        (clk),
    .reset      (reset),
    .start_mult (start_mult),
    .start_div  (start_div),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issue one start in the current cycle (cycle 0) and count cycles to done.
  task automatic applyStimulus(input logic m, input logic d, input logic [31:0] av,
                               input logic [31:0] bv, input int budget, output int cycles);
    a          = av;
    b          = bv;
    start_mult = m;
    start_div  = d;
    cycles     = -1;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk);
      #1;
      start_mult = 1'b0;
      start_div  = 1'b0;
      if (done) begin
        cycles = k;
        break;
      end
    end
  endtask

  initial begin
    reset      = 1'b1;
    start_mult = 1'b0;
    start_div  = 1'b0;
    a          = '0;
    b          = '0;
    #2;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_dz", div_zero, 0);
    checkOutput("reset_hi", hi, 0);
    checkOutput("reset_lo", lo, 0);
    tick(2);
    reset = 1'b0;
    tick(1);

    applyStimulus(1, 0, 32'd7, 32'hFFFF_FFFD, 60, lat);
    checkOutput("mul7x-3_lat", lat, 33);
    checkOutput("mul7x-3_hi", hi, 32'hFFFF_FFFF);
    checkOutput("mul7x-3_lo", lo, 32'hFFFF_FFEB);
    checkOutput("mul7x-3_dz", div_zero, 0);
    tick(1);
    checkOutput("mul_done_fall", done, 0);
    checkOutput("mul_busy_fall", busy, 0);

    applyStimulus(1, 0, 32'h8000_0000, 32'h8000_0000, 60, lat);
    checkOutput("mulmin_hi", hi, 32'h4000_0000);
    checkOutput("mulmin_lo", lo, 32'h0000_0000);
    tick(1);

    applyStimulus(0, 1, 32'hFFFF_FFF9, 32'd2, 60, lat);
    checkOutput("div-7/2_lat", lat, 34);
    checkOutput("div-7/2_lo", lo, 32'hFFFF_FFFD);
    checkOutput("div-7/2_hi", hi, 32'hFFFF_FFFF);
    checkOutput("div-7/2_dz", div_zero, 0);
    tick(1);

    // 697 / 20 = 34 rem 17 leaves hi=0x11, lo=0x22
    applyStimulus(0, 1, 32'd697, 32'd20, 60, lat);
    checkOutput("div697_lo", lo, 32'h22);
    checkOutput("div697_hi", hi, 32'h11);
    tick(1);

    applyStimulus(0, 1, 32'd5, 32'd0, 60, lat);
    checkOutput("divzero_lat", lat, 1);
    checkOutput("divzero_dz", div_zero, 1);
    checkOutput("divzero_hi", hi, 32'h11);
    checkOutput("divzero_lo", lo, 32'h22);
    tick(1);
    checkOutput("divzero_dz_fall", div_zero, 0);
    checkOutput("divzero_busy_fall", busy, 0);

    applyStimulus(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 60, lat);
    checkOutput("divovf_lo", lo, 32'h8000_0000);
    checkOutput("divovf_hi", hi, 32'h0);
    checkOutput("divovf_dz", div_zero, 0);
    tick(1);

    // Both starts together: the multiply must win even with b == 0.
    applyStimulus(1, 1, 32'd3, 32'd0, 60, lat);
    checkOutput("both_lat", lat, 33);
    checkOutput("both_dz", div_zero, 0);
    checkOutput("both_lo", lo, 32'h0);
    tick(1);
    applyStimulus(1, 0, 32'd6, 32'd2, 60, lat);
    checkOutput("mul6x2_lo", lo, 32'd12);
    tick(1);

    // start_mult at cycle 0, ignored start_div at cycle 10, reset at cycle 20
    pulses     = 0;
    a          = 32'd5;
    b          = 32'd6;
    start_mult = 1'b1;
    for (int k = 1; k < 20; k++) begin
      @(posedge clk);
      #1;
      start_mult = 1'b0;
      start_div  = 1'b0;
      if (done) pulses++;
      if (k == 10) begin
        a         = 32'd9;
        b         = 32'd0;
        start_div = 1'b1;
      end
    end
    checkOutput("abort_busy_before", busy, 1);
    reset = 1'b1;
    #1;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_hi", hi, 0);
    checkOutput("abort_lo", lo, 0);
    tick(1);
    reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    checkOutput("abort_no_done", pulses, 0);

    applyStimulus(1, 0, 32'd3, 32'd4, 60, lat);
    checkOutput("mul3x4_lat", lat, 33);
    checkOutput("mul3x4_lo", lo, 32'd12);
    checkOutput("mul3x4_hi", hi, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_div_seq.md
# mult_div_seq

Multicycle signed multiply/divide sequencer owning the HI/LO register pair of the MIPS multicycle core. The main control FSM pulses a start for MULT or DIV, stalls in a wait state while `busy` is high, and resumes on `done`. On completion the block reports divide-by-zero so the control unit can branch to its exception states. Results stay readable on `hi`/`lo` for MFHI/MFLO.

## Interface
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- start_mult  in  1  one-cycle request: signed a*b
- start_div  in  1  one-cycle request: signed a/b
- a  in  WIDTH  operand A (multiplicand / dividend), sampled with start
- b  in  WIDTH  operand B (multiplier / divisor), sampled with start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle completion pulse
- div_zero  out  1  valid with done; 1 = DIV with b==0
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

## Operation
- States: IDLE, MULT, DIV, DFIX, DONE. Encoding lives in the shared package.
- IDLE:
  - start_mult=1 latches a and b, clears the 2*WIDTH+1-bit Booth accumulator and loads count=WIDTH, then goes to MULT.
  - start_div=1 with b!=0 latches |a|, |b| and the sign bits, loads count=WIDTH, then goes to DIV.
  - start_div=1 with b==0 goes straight to DONE with div_zero set.
- Both starts high at once: start_mult wins; start_div is dropped.
- Starts in any state other than IDLE are ignored (no queueing).
- MULT: radix-2 Booth step each cycle.
  - Inspect the pair {acc[0], q_-1}: add, subtract or no-op with the multiplicand in the upper half.
  - Then arithmetic-shift right 1 and decrement count.
  - When count reaches 0: hi/lo <= product[63:32]/[31:0], go to DONE.
- DIV: restoring step each cycle on magnitudes.
  - Shift {rem, quo} left 1, then trial subtract divisor from rem.
  - If non-negative, keep the result and set the quotient LSB; otherwise restore.
  - When count reaches 0, go to DFIX.
- DFIX: apply signs.
  - lo <= quotient, negated if sign_a ^ sign_b.
  - hi <= remainder, negated if sign_a (remainder takes the dividend's sign).
  - Go to DONE.
- DONE: done=1 for one cycle, then return to IDLE.
- All arithmetic is two's complement modulo 2^WIDTH. 0x80000000 / -1 gives lo=0x80000000, hi=0, div_zero=0, with no overflow flag.
- Divide by zero: hi and lo keep their previous values.
- hi/lo change only on the MULT final step or in DFIX; they are otherwise stable across operations.

## Timing
- Reset values: all outputs 0; hi=lo=0; state IDLE; count 0.
- Start is sampled at edge E0. busy=1 from E0 until the edge that leaves DONE.
- MULT: hi/lo are valid and done=1 in the cycle after edge E0+WIDTH. That is WIDTH+1 cycles after the start cycle, i.e. 33 for WIDTH=32.
- DIV: done=1 after edge E0+WIDTH+1, i.e. 34 cycles after the start cycle for WIDTH=32.
- Divide by zero: done=1 and div_zero=1 in the cycle after E0.
- done and div_zero are registered outputs and fall at the next edge.
- A new start is accepted in the cycle after done, once back in IDLE. Back-to-back throughput is WIDTH+2 or WIDTH+3 cycles per operation.
- Reset asserted mid-operation aborts immediately: outputs, hi and lo return to 0, no done pulse.

## Structure
- Shared package `mips_pkg` holds:
  - the `mdu_state_t` enum (IDLE, MULT, DIV, DFIX, DONE);
  - the WIDTH default constant;
  - the MDU cause constant used by the control unit's exception path.
- One sub-module is natural: `div_restore_step`, a combinational shift/trial-subtract of {rem, quo}, reusable for a later unsigned DIVU.
- The Booth step stays inline.

## Test plan
- a=7, b=-3 via start_mult → done 33 cycles later; hi=0xFFFFFFFF, lo=0xFFFFFFEB; div_zero=0.
- a=0x80000000, b=0x80000000 multiply → hi=0x40000000, lo=0x00000000.
- a=-7, b=2 via start_div → done 34 cycles later; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- a=5, b=0 divide, starting with hi=0x11, lo=0x22 → done in the next cycle with div_zero=1; hi=0x11, lo=0x22 unchanged.
- a=0x80000000, b=-1 divide → lo=0x80000000, hi=0, div_zero=0.
- start_mult at cycle 0, start_div at cycle 10, reset at cycle 20:
  - the start_div is ignored;
  - at reset, busy, hi and lo drop to 0 and no done pulse occurs;
  - a fresh start_mult with a=3, b=4 then completes with lo=12.
